// File: rtl/prom_coherente_ctrl_if.sv
// Bundle of the control, sample-stream and averager-side signals of
// prom_coherente_ctrl. The master side is the register/HPS layer together
// with the sample/averager environment. The slave side is the sequencer.
interface prom_coherente_ctrl_if;
    // command / configuration
    logic        start;
    logic        stop;
    logic        cfg_we;
    logic [15:0] cfg_ptos;
    logic [15:0] cfg_frames;
    logic [15:0] cfg_navg;
    // sample stream and averager feedback
    logic        src_valid;
    logic        avg_out_valid;
    // averager control
    logic        avg_reset_n;
    logic        avg_enable;
    logic [15:0] avg_ptos;
    logic [15:0] avg_frames;
    logic        avg_in_valid;
    // output stream / status
    logic        out_valid;
    logic        out_last;
    logic        frame_done;
    logic [15:0] avg_count;
    logic        busy;
    logic        done;
    logic        cfg_err;

    modport master (
        output start, stop, cfg_we, cfg_ptos, cfg_frames, cfg_navg,
               src_valid, avg_out_valid,
        input  avg_reset_n, avg_enable, avg_ptos, avg_frames, avg_in_valid,
               out_valid, out_last, frame_done, avg_count, busy, done, cfg_err
    );

    modport slave (
        input  start, stop, cfg_we, cfg_ptos, cfg_frames, cfg_navg,
               src_valid, avg_out_valid,
        output avg_reset_n, avg_enable, avg_ptos, avg_frames, avg_in_valid,
               out_valid, out_last, frame_done, avg_count, busy, done, cfg_err
    );
endinterface

// File: rtl/prom_coherente_ctrl.sv
// Sequencer for the pipelined coherent averager: latches configuration,
// resets and clears the averager buffer, optionally waits for a trigger,
// gates the sample stream and counts averaged output frames.
// Optional feature macro: PROM_CTRL_TRIGGER_EN (adds trig_in; ARM waits for
// a registered rising edge of trig_in instead of lasting one cycle).
module prom_coherente_ctrl #(
    parameter int BUF_DEPTH = 2048
) (
    input  logic clk,
    input  logic reset_n,
`ifdef PROM_CTRL_TRIGGER_EN
    input  logic trig_in,
`endif
    prom_coherente_ctrl_if.slave bus
);

    localparam int CLR_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_CLEAR,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [CLR_W-1:0] clr_cnt_reg;
    logic [15:0] samp_cnt_reg;
    logic [15:0] avg_count_reg;
    logic [15:0] navg_reg;
    logic [15:0] ptos_reg;
    logic [15:0] frames_reg;
    logic        cfg_err_reg;
    logic        frame_done_reg;
    logic        avg_reset_n_reg;
    logic        avg_enable_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        idle_like;
    logic        cfg_ok;
    logic        out_fire;
    logic        samp_wrap;
    logic [15:0] count_inc;
    logic        trig_edge;

    assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign cfg_ok    = (ptos_reg != 16'd0) && ({16'd0, ptos_reg} <= 32'(BUF_DEPTH))
                       && (frames_reg != 16'd0);
    assign out_fire  = (state_reg == ST_RUN) && bus.avg_out_valid;
    assign samp_wrap = (samp_cnt_reg == ptos_reg - 16'd1);
    // Frame counter saturates rather than wrapping in continuous mode.
    assign count_inc = (avg_count_reg == 16'hFFFF) ? avg_count_reg : avg_count_reg + 16'd1;

`ifdef PROM_CTRL_TRIGGER_EN
    logic trig_sync_reg;
    logic trig_prev_reg;

    assign trig_edge = trig_sync_reg && !trig_prev_reg;

    // Register the trigger once and keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trig_sync_reg <= 1'b0;
            trig_prev_reg <= 1'b0;
        end else begin
            trig_sync_reg <= trig_in;
            trig_prev_reg <= trig_sync_reg;
        end
    end
`else
    assign trig_edge = 1'b1;
`endif

    // Zero-latency stream gating and output forwarding.
    assign bus.avg_in_valid = (state_reg == ST_RUN) && bus.src_valid;
    assign bus.out_valid    = out_fire;
    assign bus.out_last     = out_fire && samp_wrap;

    assign bus.avg_reset_n = avg_reset_n_reg;
    assign bus.avg_enable  = avg_enable_reg;
    assign bus.avg_ptos    = ptos_reg;
    assign bus.avg_frames  = frames_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.avg_count   = avg_count_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.cfg_err     = cfg_err_reg;

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start && cfg_ok)
                    state_next = ST_RESET;
            end
            ST_RESET: state_next = ST_CLEAR;
            ST_CLEAR: begin
                if (clr_cnt_reg == CLR_W'(BUF_DEPTH - 1))
                    state_next = ST_ARM;
            end
            ST_ARM: begin
                if (trig_edge)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (out_fire && samp_wrap && (navg_reg != 16'd0) && (count_inc == navg_reg))
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.stop)
            state_next = ST_IDLE;
    end

    // State, registered outputs (decoded from the next state so they line up
    // with the state they describe), configuration and counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            clr_cnt_reg     <= '0;
            samp_cnt_reg    <= 16'd0;
            avg_count_reg   <= 16'd0;
            navg_reg        <= 16'd0;
            ptos_reg        <= 16'd0;
            frames_reg      <= 16'd0;
            cfg_err_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
            avg_reset_n_reg <= 1'b0;
            avg_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            avg_reset_n_reg <= (state_next != ST_RESET);
            avg_enable_reg  <= (state_next == ST_ARM) || (state_next == ST_RUN)
                               || (state_next == ST_DONE);
            busy_reg        <= (state_next == ST_RESET) || (state_next == ST_CLEAR)
                               || (state_next == ST_ARM) || (state_next == ST_RUN);
            done_reg        <= (state_next == ST_DONE);

            if (bus.cfg_we) begin
                if (idle_like) begin
                    ptos_reg   <= bus.cfg_ptos;
                    frames_reg <= bus.cfg_frames;
                    navg_reg   <= bus.cfg_navg;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end

            // start is validated against the values latched before this edge.
            if (bus.start && idle_like && !bus.stop) begin
                if (cfg_ok) begin
                    cfg_err_reg   <= 1'b0;
                    avg_count_reg <= 16'd0;
                    samp_cnt_reg  <= 16'd0;
                end else begin
                    cfg_err_reg <= 1'b1;
                end
            end

            if (state_reg == ST_CLEAR)
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
            else
                clr_cnt_reg <= '0;

            frame_done_reg <= 1'b0;
            if (out_fire) begin
                if (samp_wrap) begin
                    samp_cnt_reg   <= 16'd0;
                    frame_done_reg <= 1'b1;
                    avg_count_reg  <= count_inc;
                end else begin
                    samp_cnt_reg <= samp_cnt_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prom_coherente_ctrl.sv
// Self-checking bench for prom_coherente_ctrl with randomized sample and
// averager-output streams compared against a frame-counting reference model.
module tb_prom_coherente_ctrl;

    localparam int BUF_DEPTH = 2048;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
`ifdef PROM_CTRL_TRIGGER_EN
    logic trig_in = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    prom_coherente_ctrl_if bus ();

    prom_coherente_ctrl #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef PROM_CTRL_TRIGGER_EN
        .trig_in (trig_in),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int f, input int n);
        bus.cfg_we     = 1'b1;
        bus.cfg_ptos   = 16'(p);
        bus.cfg_frames = 16'(f);
        bus.cfg_navg   = 16'(n);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // From the RESET cycle, walk through CLEAR and ARM into the first RUN cycle.
    task automatic go_to_run();
        for (int i = 0; i < BUF_DEPTH + 1; i++) tick();
`ifdef PROM_CTRL_TRIGGER_EN
        trig_in = 1'b1;
        tick();
        tick();
        trig_in = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.avg_reset_n !== 1'b0) begin bad++; $display("FAIL reset_avg_reset_n got=%b exp=0", bus.avg_reset_n); end
        total++; if (bus.avg_count !== 16'd0) begin bad++; $display("FAIL reset_avg_count got=%0d exp=0", bus.avg_count); end
        total++; if ({bus.avg_enable, bus.busy, bus.done, bus.cfg_err, bus.frame_done} !== 5'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.avg_enable, bus.busy, bus.done, bus.cfg_err, bus.frame_done}); end
        total++; if (bus.avg_ptos !== 16'd0 || bus.avg_frames !== 16'd0)
            begin bad++; $display("FAIL reset_cfg got=%0d/%0d exp=0/0", bus.avg_ptos, bus.avg_frames); end
        bus.src_valid = 1'b1; bus.avg_out_valid = 1'b1; #1;
        total++; if ({bus.avg_in_valid, bus.out_valid, bus.out_last} !== 3'b0)
            begin bad++; $display("FAIL reset_stream got=%b exp=000", {bus.avg_in_valid, bus.out_valid, bus.out_last}); end
        bus.src_valid = 1'b0; bus.avg_out_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        total++; if (bus.avg_reset_n !== 1'b1) begin bad++; $display("FAIL release_avg_reset_n got=%b exp=1", bus.avg_reset_n); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_cfg_err();
        set_cfg(0, 2, 3);
        pulse_start();
        total++; if (bus.busy !== 1'b0 || bus.cfg_err !== 1'b1)
            begin bad++; $display("FAIL ptos0 busy=%b cfg_err=%b exp busy=0 cfg_err=1", bus.busy, bus.cfg_err); end
        set_cfg(BUF_DEPTH + 1, 2, 3);
        pulse_start();
        total++; if (bus.busy !== 1'b0 || bus.cfg_err !== 1'b1)
            begin bad++; $display("FAIL ptos_big busy=%b cfg_err=%b exp busy=0 cfg_err=1", bus.busy, bus.cfg_err); end
        set_cfg(BUF_DEPTH, 0, 3);
        pulse_start();
        total++; if (bus.busy !== 1'b0 || bus.cfg_err !== 1'b1)
            begin bad++; $display("FAIL frames0 busy=%b cfg_err=%b exp busy=0 cfg_err=1", bus.busy, bus.cfg_err); end
        // Good configuration written together with start: start sees the old (bad) one.
        bus.cfg_we = 1'b1; bus.cfg_ptos = 16'd4; bus.cfg_frames = 16'd2; bus.cfg_navg = 16'd3;
        bus.start = 1'b1;
        tick();
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.cfg_err !== 1'b1 || bus.avg_ptos !== 16'd4)
            begin bad++; $display("FAIL cfg_and_start busy=%b cfg_err=%b ptos=%0d exp 0/1/4", bus.busy, bus.cfg_err, bus.avg_ptos); end
        pulse_start();
        total++; if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0 || bus.avg_reset_n !== 1'b0)
            begin bad++; $display("FAIL good_start busy=%b cfg_err=%b avg_reset_n=%b exp 1/0/0", bus.busy, bus.cfg_err, bus.avg_reset_n); end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.avg_enable !== 1'b0)
            begin bad++; $display("FAIL stop_in_reset busy=%b en=%b exp 0/0", bus.busy, bus.avg_enable); end
    endtask

    // Randomized streaming runs to DONE, checked against a frame-count model.
    task automatic test_stream();
        int p, f, nv, n, exp_cnt, budget, ov_seen, last_seen, fd_seen, clr_cycles;
        logic sv, aov, exp_last, exp_fd, finished;
        for (int run = 0; run < 3; run++) begin
            if (run == 0) begin p = 4; f = 2; nv = 3; end
            else begin p = int'($urandom_range(1, 16)); f = int'($urandom_range(1, 4)); nv = int'($urandom_range(1, 5)); end
            set_cfg(p, f, nv);
            pulse_start();
            total++; if (bus.avg_reset_n !== 1'b0 || bus.avg_enable !== 1'b0)
                begin bad++; $display("FAIL run%0d_reset_phase avg_reset_n=%b en=%b exp 0/0", run, bus.avg_reset_n, bus.avg_enable); end
            clr_cycles = 0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                tick();
                if (bus.avg_enable === 1'b0 && bus.busy === 1'b1 && bus.avg_reset_n === 1'b1) clr_cycles++;
            end
            tick();
            bus.src_valid = 1'b1; #1;
            total++; if (clr_cycles !== BUF_DEPTH || bus.avg_enable !== 1'b1)
                begin bad++; $display("FAIL run%0d_clear_len got=%0d en=%b exp=%0d en=1", run, clr_cycles, bus.avg_enable, BUF_DEPTH); end
            total++; if (bus.avg_in_valid !== 1'b0)
                begin bad++; $display("FAIL run%0d_arm_gate got=%b exp=0", run, bus.avg_in_valid); end
            total++; if (bus.avg_ptos !== 16'(p) || bus.avg_frames !== 16'(f))
                begin bad++; $display("FAIL run%0d_latched got=%0d/%0d exp=%0d/%0d", run, bus.avg_ptos, bus.avg_frames, p, f); end
`ifdef PROM_CTRL_TRIGGER_EN
            trig_in = 1'b1; tick(); tick(); trig_in = 1'b0;
`else
            tick();
`endif
            n = 0; exp_cnt = 0; exp_fd = 1'b0; finished = 1'b0; budget = 0;
            ov_seen = 0; last_seen = 0; fd_seen = 0;
            while (!finished && budget < 2000) begin
                sv  = 1'($urandom % 2);
                aov = 1'($urandom % 3 != 0);
                bus.src_valid = sv; bus.avg_out_valid = aov; #1;
                exp_last = aov && ((n % p) == p - 1);
                total++; if (bus.avg_in_valid !== sv) begin bad++; $display("FAIL run%0d_in_valid n=%0d got=%b exp=%b", run, n, bus.avg_in_valid, sv); end
                total++; if (bus.out_valid !== aov) begin bad++; $display("FAIL run%0d_out_valid n=%0d got=%b exp=%b", run, n, bus.out_valid, aov); end
                total++; if (bus.out_last !== exp_last) begin bad++; $display("FAIL run%0d_out_last n=%0d got=%b exp=%b", run, n, bus.out_last, exp_last); end
                total++; if (bus.frame_done !== exp_fd) begin bad++; $display("FAIL run%0d_frame_done n=%0d got=%b exp=%b", run, n, bus.frame_done, exp_fd); end
                total++; if (bus.avg_count !== 16'(exp_cnt)) begin bad++; $display("FAIL run%0d_avg_count got=%0d exp=%0d", run, bus.avg_count, exp_cnt); end
                total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL run%0d_running done=%b busy=%b exp 0/1", run, bus.done, bus.busy); end
                if (bus.out_valid === 1'b1) ov_seen++;
                if (bus.out_last === 1'b1) last_seen++;
                if (bus.frame_done === 1'b1) fd_seen++;
                if (aov) n++;
                exp_fd  = exp_last;
                exp_cnt = n / p;
                finished = (exp_cnt == nv) && exp_last;
                budget++;
                tick();
            end
            total++; if (!finished) begin bad++; $display("FAIL run%0d_timeout got=%0d outputs exp=%0d", run, n, p * nv); end
            if (bus.frame_done === 1'b1) fd_seen++;
            total++; if (ov_seen != p * nv || last_seen != nv || fd_seen != nv)
                begin bad++; $display("FAIL run%0d_totals got=%0d/%0d/%0d exp=%0d/%0d/%0d", run, ov_seen, last_seen, fd_seen, p * nv, nv, nv); end
            total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.avg_enable !== 1'b1 || bus.avg_count !== 16'(nv))
                begin bad++; $display("FAIL run%0d_done done=%b busy=%b en=%b cnt=%0d exp 1/0/1/%0d", run, bus.done, bus.busy, bus.avg_enable, bus.avg_count, nv); end
            bus.src_valid = 1'b1; bus.avg_out_valid = 1'b1; #1;
            total++; if (bus.out_valid !== 1'b0 || bus.avg_in_valid !== 1'b0)
                begin bad++; $display("FAIL run%0d_done_gate out_valid=%b in_valid=%b exp 0/0", run, bus.out_valid, bus.avg_in_valid); end
            tick();
            total++; if (bus.avg_count !== 16'(nv) || bus.frame_done !== 1'b0 || bus.done !== 1'b1)
                begin bad++; $display("FAIL run%0d_late_output cnt=%0d fd=%b done=%b exp %0d/0/1", run, bus.avg_count, bus.frame_done, bus.done, nv); end
            bus.src_valid = 1'b0; bus.avg_out_valid = 1'b0;
        end
    endtask

    task automatic test_cfg_in_run();
        set_cfg(5, 1, 0);
        pulse_start();
        go_to_run();
        bus.cfg_we = 1'b1; bus.cfg_ptos = 16'd7; bus.cfg_frames = 16'd9; bus.cfg_navg = 16'd1;
        tick();
        bus.cfg_we = 1'b0;
        total++; if (bus.cfg_err !== 1'b1 || bus.avg_ptos !== 16'd5 || bus.avg_frames !== 16'd1 || bus.busy !== 1'b1)
            begin bad++; $display("FAIL cfg_in_run err=%b ptos=%0d frames=%0d busy=%b exp 1/5/1/1", bus.cfg_err, bus.avg_ptos, bus.avg_frames, bus.busy); end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic test_stop();
        set_cfg(3, 1, 0);
        pulse_start();
        for (int i = 0; i < 100; i++) tick();
        bus.src_valid = 1'b1; bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.avg_enable !== 1'b0 || bus.avg_in_valid !== 1'b0 || bus.avg_reset_n !== 1'b1)
            begin bad++; $display("FAIL stop_clear busy=%b en=%b in_valid=%b rst_n=%b exp 0/0/0/1", bus.busy, bus.avg_enable, bus.avg_in_valid, bus.avg_reset_n); end
        pulse_start();
        go_to_run();
        bus.avg_out_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.avg_out_valid = 1'b0;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.avg_out_valid = 1'b1; #1;
        total++; if (bus.busy !== 1'b0 || bus.avg_enable !== 1'b0 || bus.avg_in_valid !== 1'b0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL stop_run busy=%b en=%b in_valid=%b out_valid=%b exp 0/0/0/0", bus.busy, bus.avg_enable, bus.avg_in_valid, bus.out_valid); end
        total++; if (bus.avg_count !== 16'd2)
            begin bad++; $display("FAIL stop_count got=%0d exp=2", bus.avg_count); end
        bus.avg_out_valid = 1'b0;
        bus.stop = 1'b1; bus.start = 1'b1; tick(); bus.stop = 1'b0; bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.avg_reset_n !== 1'b1)
            begin bad++; $display("FAIL stop_beats_start busy=%b rst_n=%b exp 0/1", bus.busy, bus.avg_reset_n); end
        bus.src_valid = 1'b0;
    endtask

    task automatic test_continuous();
        int n, budget;
        logic done_seen;
        set_cfg(1, 1, 0);
        pulse_start();
        go_to_run();
        n = 0; budget = 0; done_seen = 1'b0;
        while (n < 1000 && budget < 4000) begin
            bus.avg_out_valid = 1'($urandom % 4 != 0);
            if (bus.avg_out_valid) n++;
            tick();
            if (bus.done === 1'b1) done_seen = 1'b1;
            budget++;
        end
        bus.avg_out_valid = 1'b0;
        total++; if (n != 1000) begin bad++; $display("FAIL cont_timeout got=%0d exp=1000", n); end
        total++; if (bus.avg_count !== 16'd1000 || done_seen !== 1'b0 || bus.busy !== 1'b1)
            begin bad++; $display("FAIL continuous cnt=%0d done_seen=%b busy=%b exp 1000/0/1", bus.avg_count, done_seen, bus.busy); end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

`ifdef PROM_CTRL_TRIGGER_EN
    task automatic test_trigger();
        int leaks;
        set_cfg(2, 1, 0);
        trig_in = 1'b1;
        pulse_start();
        for (int i = 0; i < BUF_DEPTH + 1; i++) tick();
        bus.src_valid = 1'b1;
        leaks = 0;
        for (int i = 0; i < 48; i++) begin
            #1; if (bus.avg_in_valid !== 1'b0) leaks++;
            tick();
        end
        trig_in = 1'b0; tick(); tick();
        trig_in = 1'b1; #1;
        total++; if (leaks != 0 || bus.avg_in_valid !== 1'b0 || bus.avg_enable !== 1'b1)
            begin bad++; $display("FAIL trig_arm_wait leaks=%0d in_valid=%b en=%b exp 0/0/1", leaks, bus.avg_in_valid, bus.avg_enable); end
        tick();
        total++; if (bus.avg_in_valid !== 1'b0)
            begin bad++; $display("FAIL trig_detect_cycle got=%b exp=0", bus.avg_in_valid); end
        tick();
        total++; if (bus.avg_in_valid !== 1'b1)
            begin bad++; $display("FAIL trig_run got=%b exp=1", bus.avg_in_valid); end
        trig_in = 1'b0; bus.src_valid = 1'b0;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_run();
        set_cfg(2, 1, 0);
        pulse_start();
        go_to_run();
        bus.avg_out_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        total++; if (bus.avg_reset_n !== 1'b0 || bus.avg_count !== 16'd0 || bus.busy !== 1'b0 || bus.avg_ptos !== 16'd0)
            begin bad++; $display("FAIL mid_run_reset rst_n=%b cnt=%0d busy=%b ptos=%0d exp 0/0/0/0", bus.avg_reset_n, bus.avg_count, bus.busy, bus.avg_ptos); end
        total++; if (bus.avg_enable !== 1'b0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL mid_run_reset_stream en=%b out_valid=%b exp 0/0", bus.avg_enable, bus.out_valid); end
        bus.avg_out_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        total++; if (bus.avg_reset_n !== 1'b1)
            begin bad++; $display("FAIL mid_run_release got=%b exp=1", bus.avg_reset_n); end
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_ptos = 16'd0; bus.cfg_frames = 16'd0; bus.cfg_navg = 16'd0;
        bus.src_valid = 1'b0; bus.avg_out_valid = 1'b0;
        test_reset();
        test_cfg_err();
        test_stream();
        test_cfg_in_run();
        test_stop();
        test_continuous();
`ifdef PROM_CTRL_TRIGGER_EN
        test_trigger();
`endif
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prom_coherente_ctrl.md
# prom_coherente_ctrl

Sequencer for the pipelined coherent averager in the lock-in processing chain. Latches averaging configuration, clears the averager buffer, optionally aligns acquisition start to an external trigger, gates the incoming sample stream, and counts averaged output frames until a programmed number of frames has been produced. Sits between the register/HPS control layer and the averager, and between the ADC sample stream and the averager input.

## Interface
Parameters:
- BUF_DEPTH, 2048: averager buffer depth; also the clear-phase length in cycles.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle start command
- stop  in  1  single-cycle abort; has priority over start
- cfg_we  in  1  configuration write strobe
- cfg_ptos  in  16  points per signal cycle
- cfg_frames  in  16  frames averaged per output frame
- cfg_navg  in  16  averaged frames to produce; 0 = continuous
- trig_in  in  1  acquisition trigger (port exists only with PROM_CTRL_TRIGGER_EN)
- src_valid  in  1  sample valid from upstream
- avg_out_valid  in  1  averager output valid
- avg_reset_n  out  1  averager reset, active-low
- avg_enable  out  1  averager enable
- avg_ptos  out  16  latched points per cycle
- avg_frames  out  16  latched frames to average
- avg_in_valid  out  1  gated sample valid to averager
- out_valid  out  1  forwarded averager output valid
- out_last  out  1  marks last sample of an averaged frame
- frame_done  out  1  one-cycle pulse per completed averaged frame
- avg_count  out  16  completed averaged frames since start
- busy  out  1  high in RESET, CLEAR, ARM, RUN
- done  out  1  high in DONE
- cfg_err  out  1  sticky configuration/command error

## Operation
- States: IDLE, RESET, CLEAR, ARM, RUN, DONE.
- cfg_we accepted only in IDLE/DONE: latches avg_ptos, avg_frames, navg. cfg_we in any other state: ignored, cfg_err set.
- start in IDLE/DONE: if avg_ptos==0, avg_ptos>BUF_DEPTH or avg_frames==0 then stay, set cfg_err; else clear cfg_err, avg_count, out counter, go RESET. start in busy states ignored.
- RESET: avg_reset_n=0 for exactly 1 cycle, then CLEAR.
- CLEAR: avg_enable=0 for exactly BUF_DEPTH cycles (averager zeroes one buffer entry per cycle), then ARM.
- ARM: avg_enable=1, avg_in_valid=0; go RUN (see Configuration).
- RUN: avg_in_valid = src_valid. out_valid = avg_out_valid. Sample counter increments on avg_out_valid, wraps at avg_ptos-1; at wrap out_last=1, frame_done pulses, avg_count increments (saturates at 0xFFFF). When navg!=0 and the increment makes avg_count==navg: go DONE on the next edge.
- DONE: avg_enable=1, avg_in_valid=0, out_valid=0 (late averager outputs discarded, not counted).
- stop in any state: go IDLE next edge; avg_enable=0, avg_in_valid=0. avg_count retained.
- IDLE: avg_reset_n=1, avg_enable=0.

## Timing
- Reset values: avg_reset_n=0 during reset then 1; avg_enable=0, avg_in_valid=0, out_valid=0, out_last=0, frame_done=0, avg_count=0, busy=0, done=0, cfg_err=0, avg_ptos=0, avg_frames=0, state IDLE.
- avg_in_valid, out_valid, out_last combinational from state and inputs (zero latency); all other outputs registered.
- start sampled at edge t: RESET during cycle t+1, CLEAR t+2..t+1+BUF_DEPTH, ARM at t+2+BUF_DEPTH, RUN at t+3+BUF_DEPTH (no trigger).
- frame_done and avg_count update one cycle after the wrapping avg_out_valid.
- Simultaneous stop and start: stop wins. Simultaneous cfg_we and start in IDLE: configuration latched, start validated against previously latched values.
- reset_n low mid-RUN: all outputs to reset values next edge; averager receives avg_reset_n=0.

## Configuration
- PROM_CTRL_TRIGGER_EN defined: trig_in present, registered once; ARM waits for a rising edge (registered 0->1); RUN entered on the cycle after the edge is detected. Edges outside ARM ignored.
- Undefined: no trig_in port; ARM lasts exactly one cycle.

## Test plan
- cfg ptos=4, frames=2, navg=3, start, src_valid continuous -> CLEAR exactly 2048 cycles, 12 out_valid, out_last every 4th, 3 frame_done, done=1, avg_count=3.
- cfg ptos=0, start -> state stays IDLE, cfg_err=1, busy=0; valid cfg then start -> cfg_err=0, busy=1.
- navg=0, run 1000 frames -> never DONE, avg_count=1000.
- stop during CLEAR and mid-RUN -> IDLE next edge, avg_enable=0, avg_in_valid=0 same cycle as state change.
- cfg_we during RUN -> cfg_err=1, avg_ptos unchanged.
- With PROM_CTRL_TRIGGER_EN: trig_in held high before ARM then low-high 50 cycles into ARM -> RUN one cycle after the detected edge, avg_in_valid low until then.
